seq_detector_param: RTL and testbench

- Parametrised serial pattern detector. Generalises the fixed 4-bit "1101" Mealy overlap detector.
- Supports:
  - configurable pattern length;
  - reset-time and run-time programmable pattern;
  - selectable overlap / non-overlap;
  - selectable Mealy (combinational) or Moore (registered) output;
  - input qualifier;
  - saturating match counter.
- Sits on a 1-bit serial data path, for example framing/sync-word detection after a deserialiser. Drives a match pulse and a statistics count.

---
 rtl/seq_detector_param.sv | 110 +++++++++++
 tb/tb_seq_detector_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector for sync-word/framing detection on a 1-bit path.
// Latency: z is combinational with the accepting bit (MOORE=0) or one cycle later (MOORE=1).
// Backpressure: none; en qualifies each bit, and unqualified cycles leave the history untouched.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (highest priority)
//   en         a bit on x is consumed only when en=1
//   x          serial data bit
//   pat_load   load pat_in into the pattern register and flush history
//   pat_in     new N-bit pattern, MSB = oldest bit
//   cnt_clr    synchronous clear of match_cnt (wins over a same-cycle match)
//   z          match pulse
//   match_cnt  saturating count of matches
//   cnt_sat    high while match_cnt is all-ones
module seq_detector_param #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b0,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // fill counts valid history bits and saturates at N-1, so it never needs
  // more than clog2(N) bits.
  localparam int unsigned   FW       = $clog2(N);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

  logic [N-2:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [N-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q;

  logic [N-1:0]     window;
  logic             match;

  // Window = the N-1 remembered bits plus the bit on the wire this cycle.
  assign window = {hist_q, x};

  // A match needs a full history so that stale zeros after reset/load/flush
  // can never complete a pattern that begins with zeros.
  assign match = en & ~pat_load & (fill_q == FILL_MAX) & (window == pat_q);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    if (pat_load) begin
      // The bit presented in the load cycle is dropped on purpose: the new
      // pattern starts from a clean history with the next consumed bit.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (match && !OVERLAP) begin
        // Non-overlap: the accepting bit is not reused for the next match.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[N-2:0];
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + FW'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      // Loads match regardless of en so the Moore pulse lasts exactly one cycle.
      z_q    <= match;
    end
  end

  assign z         = MOORE ? z_q : match;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int NI = 5;

  // Per-instance configuration:
  //   0: overlap Mealy    1: non-overlap Mealy   2: overlap Moore
  //   3: overlap Mealy with 2-bit counter         4: N=7 non-overlap Moore
  int np   [NI] = '{4, 4, 4, 4, 7};
  int ov   [NI] = '{1, 0, 1, 1, 0};
  int mo   [NI] = '{0, 0, 1, 0, 1};
  int cw   [NI] = '{8, 8, 8, 2, 8};
  int pdef [NI] = '{13, 13, 13, 13, 89};  // 4'b1101 and 7'b1011001

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        x = 1'b0;
  logic        pat_load = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] pin = '0;

  logic       z0, z1, z2, z3, z4;
  logic       s0, s1, s2, s3, s4;
  logic [7:0] c0, c1, c2, c4;
  logic [1:0] c3;

  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pin[3:0]),
    .cnt_clr(cnt_clr), .z(z0), .match_cnt(c0), .cnt_sat(s0));
  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pin[3:0]),
    .cnt_clr(cnt_clr), .z(z1), .match_cnt(c1), .cnt_sat(s1));
  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8)) u_mo (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pin[3:0]),
    .cnt_clr(cnt_clr), .z(z2), .match_cnt(c2), .cnt_sat(s2));
  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pin[3:0]),
    .cnt_clr(cnt_clr), .z(z3), .match_cnt(c3), .cnt_sat(s3));
  seq_detector_param #(.N(7), .PATTERN(7'b1011001), .OVERLAP(1'b0), .MOORE(1'b1), .CNT_W(8)) u_n7 (
    .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pin[6:0]),
    .cnt_clr(cnt_clr), .z(z4), .match_cnt(c4), .cnt_sat(s4));

  logic        zo [NI];
  logic        so [NI];
  logic [31:0] co [NI];
  assign zo[0] = z0; assign zo[1] = z1; assign zo[2] = z2; assign zo[3] = z3; assign zo[4] = z4;
  assign so[0] = s0; assign so[1] = s1; assign so[2] = s2; assign so[3] = s3; assign so[4] = s4;
  assign co[0] = 32'(c0); assign co[1] = 32'(c1); assign co[2] = 32'(c2);
  assign co[3] = 32'(c3); assign co[4] = 32'(c4);

  // Reference model: history kept as an integer of recent bits, the number
  // of bits seen since the last flush, the pattern and the match count.
  int mh  [NI];
  int mf  [NI];
  int mp  [NI];
  int mc  [NI];
  bit mzq [NI];
  bit mm  [NI];

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model mid-cycle, then advance the model at the rising edge.
  task automatic step(input logic e, input logic xi, input logic ld,
                      input logic [15:0] pi, input logic cl, input logic r);
    int pm, hm, win, cmax;
    @(negedge clk);
    en = e; x = xi; pat_load = ld; pin = pi; cnt_clr = cl; rst = r;
    #1;
    for (int i = 0; i < NI; i++) begin
      pm   = (1 << np[i]) - 1;
      win  = ((mh[i] << 1) | int'(xi)) & pm;
      cmax = (1 << cw[i]) - 1;
      mm[i] = e && !ld && (mf[i] >= np[i] - 1) && (win == mp[i]);
      if (armed) begin
        chk($sformatf("z%0d", i), 32'(zo[i]), (mo[i] != 0) ? 32'(mzq[i]) : 32'(mm[i]));
        chk($sformatf("cnt%0d", i), co[i], 32'(mc[i]));
        chk($sformatf("sat%0d", i), 32'(so[i]), 32'(mc[i] == cmax));
      end
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      pm   = (1 << np[i]) - 1;
      hm   = (1 << (np[i] - 1)) - 1;
      cmax = (1 << cw[i]) - 1;
      if (r) begin
        mh[i] = 0; mf[i] = 0; mp[i] = pdef[i]; mc[i] = 0; mzq[i] = 1'b0;
      end else begin
        mzq[i] = mm[i];
        if (cl) mc[i] = 0;
        else if (mm[i] && mc[i] < cmax) mc[i] = mc[i] + 1;
        if (ld) begin
          mp[i] = int'(pi) & pm; mh[i] = 0; mf[i] = 0;
        end else if (e) begin
          if (mm[i] && ov[i] == 0) begin
            mh[i] = 0; mf[i] = 0;
          end else begin
            mh[i] = ((mh[i] << 1) | int'(xi)) & hm;
            if (mf[i] < np[i] - 1) mf[i] = mf[i] + 1;
          end
        end
      end
    end
    armed = 1'b1;
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    logic [15:0] t;
    t = v;
    for (int k = n - 1; k >= 0; k--) step(1'b1, t[k], 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic e, xi, ld, cl, r;
    logic [15:0] pi;

    // Reset state
    do_reset();
    do_reset();
    #1;
    chk("rst_cnt", co[0], 32'd0);
    chk("rst_zmoore", 32'(zo[2]), 32'd0);
    chk("rst_sat", 32'(so[3]), 32'd0);

    // 1101101: overlap gives two matches, non-overlap gives one
    bits(16'b1101101, 7);
    #1;
    chk("ov_cnt", co[0], 32'd2);
    chk("noov_cnt", co[1], 32'd1);

    // Moore pulse one cycle after the accepting bit, independent of en
    do_reset();
    bits(16'b1101, 4);
    #1;
    chk("moore_hi", 32'(zo[2]), 32'd1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("moore_lo", 32'(zo[2]), 32'd0);

    // Qualifier: an en=0 bit is not consumed
    do_reset();
    bits(16'b11, 2);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    bits(16'b01, 2);
    #1;
    chk("qual_cnt", co[0], 32'd1);

    // Reset mid-stream discards history
    do_reset();
    bits(16'b110, 3);
    do_reset();
    bits(16'b1, 1);
    #1;
    chk("midrst_cnt", co[0], 32'd0);

    // Pattern load: the load-cycle bit is ignored, new pattern applies afterwards
    do_reset();
    bits(16'b11, 2);
    step(1'b1, 1'b0, 1'b1, 16'b0110, 1'b0, 1'b0);
    bits(16'b110, 3);
    #1;
    chk("load_ignx", co[0], 32'd0);
    bits(16'b0110, 4);
    #1;
    chk("load_match", co[0], 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'b0110, 1'b0, 1'b0);
    bits(16'b1101, 4);
    #1;
    chk("load_old", co[0], 32'd1);

    // Saturation with a 2-bit counter, clear beats a same-cycle match
    do_reset();
    for (int k = 0; k < 5; k++) bits(16'b1101, 4);
    #1;
    chk("sat_cnt", co[3], 32'd3);
    chk("sat_flag", 32'(so[3]), 32'd1);
    bits(16'b110, 3);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    chk("clr_win", co[3], 32'd0);
    bits(16'b1101, 4);
    #1;
    chk("after_clr", co[3], 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 63) == 0);
      cl = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 3) != 0);
      xi = 1'($urandom_range(0, 1));
      pi = 16'($urandom);
      step(e, xi, ld, pi, cl, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
